y86_execute_pipe: RTL and testbench

Pipelined, parametrised successor to the SEQ execute stage. It sits between decode and memory in the pipelined Y86-64 core and computes valE and Cnd. It holds the condition-code register (ZF/SF/OF) internally, with a per-update suppress input for downstream exceptions. It adds valid/ready handshakes on both sides, a registered output stage with backpressure, and an optional iterative `mulq` (OPq ifun 4) run by a small state machine.

---
 rtl/y86_execute_pipe.sv | 223 ++++++++++++++++++++++
 tb/tb_y86_execute_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/y86_execute_pipe.sv
// Pipelined Y86-64 execute stage: computes valE/Cnd, owns the ZF/SF/OF register,
// and runs an optional iterative shift-add mulq behind valid/ready handshakes.
module y86_execute_pipe #(
    parameter int DATA_W     = 64,
    parameter bit ENABLE_MUL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valB,
    input  logic [DATA_W-1:0] valC,
    input  logic              cc_suppress,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_icode,
    output logic [DATA_W-1:0] out_valE,
    output logic [DATA_W-1:0] out_valA,
    output logic              out_Cnd,
    output logic              out_err,
    output logic              zf,
    output logic              sf,
    output logic              of
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam int                CNT_W      = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_INIT   = CNT_W'(DATA_W);
    localparam logic [DATA_W-1:0] WORD_BYTES = DATA_W'(DATA_W / 8);

    logic [1:0]        state;
    logic [CNT_W-1:0]  mul_cnt;
    logic [DATA_W-1:0] mul_cand;
    logic [DATA_W-1:0] mul_plier;
    logic [DATA_W-1:0] mul_acc;
    logic [DATA_W-1:0] mul_vala;

    logic [DATA_W-1:0] sum_ab;
    logic [DATA_W-1:0] diff_ba;
    logic [DATA_W-1:0] dec_vale;
    logic              dec_cnd;
    logic              dec_err;
    logic              dec_cc_we;
    logic              dec_is_mul;
    logic              dec_of;
    logic              cond;

    logic out_free;
    logic accept;
    logic load_single;
    logic mul_load;

    assign sum_ab  = valB + valA;
    assign diff_ba = valB - valA;

    always_comb begin
        cond = 1'b0;
        case (ifun)
            4'd0: cond = 1'b1;
            4'd1: cond = (sf ^ of) | zf;
            4'd2: cond = sf ^ of;
            4'd3: cond = zf;
            4'd4: cond = ~zf;
            4'd5: cond = ~(sf ^ of);
            4'd6: cond = ~(sf ^ of) & ~zf;
            default: cond = 1'b0;
        endcase
    end

    // Single-cycle result, condition and error decode for the instruction on the input side.
    always_comb begin
        dec_vale   = '0;
        dec_cnd    = 1'b0;
        dec_err    = 1'b0;
        dec_cc_we  = 1'b0;
        dec_is_mul = 1'b0;
        dec_of     = 1'b0;
        case (icode)
            4'h0, 4'h1: dec_vale = '0;
            4'h2: begin
                if (ifun > 4'd6) dec_err = 1'b1;
                else begin
                    dec_vale = valA;
                    dec_cnd  = cond;
                end
            end
            4'h3: dec_vale = valC;
            4'h4, 4'h5: dec_vale = valB + valC;
            4'h6: begin
                case (ifun)
                    4'd0: begin
                        dec_vale  = sum_ab;
                        dec_cc_we = 1'b1;
                        dec_of    = (valA[DATA_W-1] == valB[DATA_W-1]) &&
                                    (sum_ab[DATA_W-1] != valA[DATA_W-1]);
                    end
                    4'd1: begin
                        dec_vale  = diff_ba;
                        dec_cc_we = 1'b1;
                        dec_of    = (valA[DATA_W-1] != valB[DATA_W-1]) &&
                                    (diff_ba[DATA_W-1] != valB[DATA_W-1]);
                    end
                    4'd2: begin
                        dec_vale  = valB & valA;
                        dec_cc_we = 1'b1;
                    end
                    4'd3: begin
                        dec_vale  = valB ^ valA;
                        dec_cc_we = 1'b1;
                    end
                    4'd4: begin
                        if (ENABLE_MUL) dec_is_mul = 1'b1;
                        else            dec_err    = 1'b1;
                    end
                    default: dec_err = 1'b1;
                endcase
            end
            4'h7: begin
                if (ifun > 4'd6) dec_err = 1'b1;
                else             dec_cnd = cond;
            end
            4'h8, 4'hA: dec_vale = valB - WORD_BYTES;
            4'h9, 4'hB: dec_vale = valB + WORD_BYTES;
            default: dec_err = 1'b1;
        endcase
    end

    assign out_free    = ~out_valid | out_ready;
    assign in_ready    = ~rst & (state == S_IDLE) & out_free;
    assign accept      = in_valid & in_ready;
    assign load_single = accept & ~dec_is_mul;
    assign mul_load    = (((state == S_MUL) && (mul_cnt == '0)) || (state == S_WAIT)) && out_free;

    // Multiplier FSM: one shift-add step per cycle, then park in WAIT if the output is still occupied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mul_cnt   <= '0;
            mul_cand  <= '0;
            mul_plier <= '0;
            mul_acc   <= '0;
            mul_vala  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && dec_is_mul) begin
                        mul_cand  <= valB;
                        mul_plier <= valA;
                        mul_acc   <= '0;
                        mul_vala  <= valA;
                        mul_cnt   <= CNT_INIT;
                        state     <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (mul_cnt != '0) begin
                        if (mul_plier[0]) mul_acc <= mul_acc + mul_cand;
                        mul_cand  <= mul_cand << 1;
                        mul_plier <= mul_plier >> 1;
                        mul_cnt   <= mul_cnt - CNT_W'(1);
                    end else begin
                        state <= out_free ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (out_free) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_icode <= 4'h0;
            out_valE  <= '0;
            out_valA  <= '0;
            out_Cnd   <= 1'b0;
            out_err   <= 1'b0;
        end else if (load_single) begin
            out_valid <= 1'b1;
            out_icode <= icode;
            out_valE  <= dec_vale;
            out_valA  <= valA;
            out_Cnd   <= dec_cnd;
            out_err   <= dec_err;
        end else if (mul_load) begin
            out_valid <= 1'b1;
            out_icode <= 4'h6;
            out_valE  <= mul_acc;
            out_valA  <= mul_vala;
            out_Cnd   <= 1'b0;
            out_err   <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // CC is written on the same edge the result enters the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zf <= 1'b1;
            sf <= 1'b0;
            of <= 1'b0;
        end else if (load_single && dec_cc_we && !cc_suppress) begin
            zf <= (dec_vale == '0);
            sf <= dec_vale[DATA_W-1];
            of <= dec_of;
        end else if (mul_load && !cc_suppress) begin
            zf <= (mul_acc == '0);
            sf <= mul_acc[DATA_W-1];
            of <= 1'b0;
        end
    end

endmodule

// File: tb/tb_y86_execute_pipe.sv
// Scoreboard bench for y86_execute_pipe: directed instructions push expected results,
// a negedge monitor pops and compares every output the DUT hands over.
module tb_y86_execute_pipe;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [W-1:0] valA;
    logic [W-1:0] valB;
    logic [W-1:0] valC;
    logic         cc_suppress;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_icode;
    logic [W-1:0] out_valE;
    logic [W-1:0] out_valA;
    logic         out_Cnd;
    logic         out_err;
    logic         zf;
    logic         sf;
    logic         of;

    typedef struct {
        string        name;
        logic [3:0]   icode;
        logic [W-1:0] vale;
        logic [W-1:0] vala;
        logic         cnd;
        logic         err;
        logic         zf;
        logic         sf;
        logic         of;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   last_wait = 0;

    y86_execute_pipe #(.DATA_W(W), .ENABLE_MUL(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .ifun(ifun),
        .valA(valA), .valB(valB), .valC(valC),
        .cc_suppress(cc_suppress),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_icode(out_icode), .out_valE(out_valE), .out_valA(out_valA),
        .out_Cnd(out_Cnd), .out_err(out_err),
        .zf(zf), .sf(sf), .of(of)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_output actual_valE=%h expected=none", out_valE);
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, ".icode"}, W'(out_icode), W'(e.icode));
                checkOutput({e.name, ".valE"},  out_valE,      e.vale);
                checkOutput({e.name, ".valA"},  out_valA,      e.vala);
                checkOutput({e.name, ".Cnd"},   W'(out_Cnd),   W'(e.cnd));
                checkOutput({e.name, ".err"},   W'(out_err),   W'(e.err));
                checkOutput({e.name, ".zf"},    W'(zf),        W'(e.zf));
                checkOutput({e.name, ".sf"},    W'(sf),        W'(e.sf));
                checkOutput({e.name, ".of"},    W'(of),        W'(e.of));
            end
        end
    end

    task automatic applyStimulus(input string name, input logic [3:0] ic, input logic [3:0] fn,
                                 input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                                 input logic sup, input logic [W-1:0] ev, input logic ecnd,
                                 input logic eerr, input logic ezf, input logic esf, input logic eof);
        exp_t e;
        int   n;
        icode       = ic;
        ifun        = fn;
        valA        = a;
        valB        = b;
        valC        = c;
        cc_suppress = sup;
        in_valid    = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        if (!in_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s.accept_timeout actual=in_ready_low expected=accepted", name);
        end else begin
            e.name = name; e.icode = ic; e.vale = ev; e.vala = a;
            e.cnd = ecnd; e.err = eerr; e.zf = ezf; e.sf = esf; e.of = eof;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        cc_suppress = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        int  n;
        logic busy_ok;
        logic saw_out;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cc_suppress = 1'b0;
        icode = 4'h1; ifun = 4'h0; valA = '0; valB = '0; valC = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.in_ready", W'(in_ready), W'(0));
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset.zf", W'(zf), W'(1));
        checkOutput("reset.sf", W'(sf), W'(0));
        checkOutput("reset.of", W'(of), W'(0));
        checkOutput("reset.out_valid", W'(out_valid), W'(0));
        checkOutput("reset.out_valE", out_valE, W'(0));
        checkOutput("release.in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1;

        applyStimulus("sub10", 4'h6, 4'h1, 64'd10, 64'd10, 64'd0, 1'b0, 64'd0, 0, 0, 1, 0, 0);
        applyStimulus("add25", 4'h6, 4'h0, 64'd10, 64'd15, 64'd0, 1'b0, 64'd25, 0, 0, 0, 0, 0);
        applyStimulus("add_ovf", 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0,
                      1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 1, 1);
        applyStimulus("jl", 4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 0, 0, 0, 1, 1);
        applyStimulus("jne", 4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 1, 0, 0, 1, 1);
        applyStimulus("rrmov", 4'h2, 4'h0, 64'h55, 64'd0, 64'd0, 1'b0, 64'h55, 1, 0, 0, 1, 1);
        applyStimulus("irmov", 4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 1'b0, 64'h1234, 0, 0, 0, 1, 1);
        applyStimulus("mrmov", 4'h5, 4'h0, 64'd0, 64'h100, 64'h20, 1'b0, 64'h120, 0, 0, 0, 1, 1);
        applyStimulus("nop", 4'h1, 4'h0, 64'h3, 64'h9, 64'h9, 1'b0, 64'd0, 0, 0, 0, 1, 1);
        applyStimulus("call", 4'h8, 4'h0, 64'd0, 64'h200, 64'd0, 1'b0, 64'h1F8, 0, 0, 0, 1, 1);
        applyStimulus("ret", 4'h9, 4'h0, 64'd0, 64'h1F8, 64'd0, 1'b0, 64'h200, 0, 0, 0, 1, 1);
        applyStimulus("and", 4'h6, 4'h2, 64'hF0, 64'h3C, 64'd0, 1'b0, 64'h30, 0, 0, 0, 0, 0);
        applyStimulus("xor", 4'h6, 4'h3, 64'hFF, 64'hFF, 64'd0, 1'b0, 64'd0, 0, 0, 1, 0, 0);
        applyStimulus("sub_ovf", 4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 1'b0,
                      64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 1);
        applyStimulus("jle", 4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 1, 0, 0, 0, 1);
        applyStimulus("jg", 4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 0, 0, 0, 0, 1);
        applyStimulus("j_bad", 4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 0, 1, 0, 0, 1);
        applyStimulus("cmove", 4'h2, 4'h3, 64'h99, 64'd0, 64'd0, 1'b0, 64'h99, 0, 0, 0, 0, 1);

        applyStimulus("mulq", 4'h6, 4'h4, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 1'b0,
                      64'hFFFF_FFFF_FFFF_FFEB, 0, 0, 0, 1, 0);
        n = 0;
        busy_ok = 1'b1;
        while (!out_valid && n < 200) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("mul.latency", W'(n), W'(W + 1));
        checkOutput("mul.in_ready_low", W'(busy_ok), W'(1));

        applyStimulus("sub10b", 4'h6, 4'h1, 64'd10, 64'd10, 64'd0, 1'b0, 64'd0, 0, 0, 1, 0, 0);

        icode = 4'h6; ifun = 4'h4; valA = 64'd7; valB = 64'hFFFF_FFFF_FFFF_FFFD; in_valid = 1'b1;
        @(negedge clk);
        checkOutput("abort.accept", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (29) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        saw_out = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) saw_out = 1'b1;
        end
        checkOutput("abort.no_output", W'(saw_out), W'(0));
        checkOutput("abort.zf", W'(zf), W'(1));
        checkOutput("abort.sf", W'(sf), W'(0));
        checkOutput("abort.in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        applyStimulus("pushq", 4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 1'b0, 64'hF8, 0, 0, 1, 0, 0);
        icode = 4'h6; ifun = 4'h0; valA = 64'd1; valB = 64'd1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp.out_valid", W'(out_valid), W'(1));
            checkOutput("bp.valE_stable", out_valE, 64'hF8);
            checkOutput("bp.in_ready", W'(in_ready), W'(0));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        applyStimulus("add_after_bp", 4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 1'b0, 64'd2, 0, 0, 0, 0, 0);
        checkOutput("bp.accept_on_release", W'(last_wait), W'(0));

        applyStimulus("sub_suppressed", 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 1'b1, 64'd0, 0, 0, 0, 0, 0);
        applyStimulus("bad_icode", 4'hC, 4'h0, 64'h77, 64'h5, 64'h5, 1'b0, 64'd0, 0, 1, 0, 0, 0);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard.drained", W'(sb.size()), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
